// File: rtl/rlink_cext_bufio.sv
// rlink_cext_bufio: buffered, paced rlink C-side interface for tbcore.
// Define RLINK_CEXT_BUFIO_TRACE_EN for per-byte event tracing.

package rlink_cext_pkg;

    // C-side stand-ins carrying the DPI signatures.
    // The C-linked build replaces these with the real imports.
    int rx_src[$];
    int get_log[$];
    int put_log[$];

    function automatic int rlink_cext_getbyte_dpi(input int clk);
        get_log.push_back(clk);
        if (rx_src.size() == 0) return -1;
        return rx_src.pop_front();
    endfunction

    function automatic int rlink_cext_putbyte_dpi(input int dat);
        put_log.push_back(dat);
        return 0;
    endfunction

endpackage

module rlink_cext_bufio #(
    parameter int RXDEPTH  = 16,
    parameter int TXDEPTH  = 16,
    parameter int POLLWAIT = 0,
    parameter int TXPACE   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              clk_cycle,
    output logic [7:0]               rx_data,
    output logic                     rx_val,
    input  logic                     rx_hold,
    input  logic [7:0]               tx_data,
    input  logic                     tx_ena,
    output logic                     tx_busy,
    output logic [$clog2(RXDEPTH):0] rx_fill,
    output logic [$clog2(TXDEPTH):0] tx_fill,
    output logic                     sim_end,
    output logic                     tx_ovfl
);

    import rlink_cext_pkg::*;

    localparam int RAW = $clog2(RXDEPTH);
    localparam int TAW = $clog2(TXDEPTH);
    localparam logic [RAW:0] RX_FULL = (RAW+1)'(RXDEPTH);
    localparam logic [TAW:0] TX_FULL = (TAW+1)'(TXDEPTH);

    typedef struct packed {
        logic [RXDEPTH-1:0][7:0] mem;
        logic [RAW-1:0]          wr;
        logic [RAW-1:0]          rd;
        logic [RAW:0]            cnt;
        logic [31:0]             bo;
        logic                    fin;
    } rx_st_t;

    typedef struct packed {
        logic [TXDEPTH-1:0][7:0] mem;
        logic [TAW-1:0]          wr;
        logic [TAW-1:0]          rd;
        logic [TAW:0]            cnt;
        logic [31:0]             pace;
    } tx_st_t;

    rx_st_t rx_q;
    tx_st_t tx_q;
    logic   ovfl_q;
    logic   rx_poll;
    logic   rx_pop;
    logic   tx_push;
    logic   tx_drain;

    // Next RX state from the poll result; the whole
    // update lives here so the C call happens once per edge.
    function automatic rx_st_t rx_next(
        input rx_st_t cur,
        input logic   polled,
        input int     res,
        input logic   pop
    );
        rx_st_t nxt;
        logic   push;
        nxt  = cur;
        push = 1'b0;
        if (polled) begin
            if (res >= 0) begin
                push = 1'b1;
                nxt.mem[cur.wr] = res[7:0];
                nxt.wr = cur.wr + 1'b1;
`ifdef RLINK_CEXT_BUFIO_TRACE_EN
                $display("%0d getbyte %02x", clk_cycle, res[7:0]);
`endif
            end else if (res == -1) begin
                if (POLLWAIT != 0) begin
                    nxt.bo = 32'(POLLWAIT);
`ifdef RLINK_CEXT_BUFIO_TRACE_EN
                    $display("%0d backoff %02x", clk_cycle, 8'hff);
`endif
                end
            end else begin
                nxt.fin = 1'b1;
`ifdef RLINK_CEXT_BUFIO_TRACE_EN
                $display("%0d sim_end %02x", clk_cycle, res[7:0]);
`endif
            end
        end else if (cur.bo != '0) begin
            nxt.bo = cur.bo - 32'd1;
        end
        if (pop) nxt.rd = cur.rd + 1'b1;
        if (push && !pop) nxt.cnt = cur.cnt + 1'b1;
        else if (!push && pop) nxt.cnt = cur.cnt - 1'b1;
        return nxt;
    endfunction

    // Next TX state; push and drain may share an edge.
    function automatic tx_st_t tx_next(
        input tx_st_t     cur,
        input logic       push,
        input logic [7:0] dat,
        input logic       drain
    );
        tx_st_t nxt;
        nxt = cur;
        if (push) begin
            nxt.mem[cur.wr] = dat;
            nxt.wr = cur.wr + 1'b1;
        end
        if (drain) begin
            nxt.rd   = cur.rd + 1'b1;
            nxt.pace = 32'(TXPACE - 1);
        end else if (cur.pace != '0) begin
            nxt.pace = cur.pace - 32'd1;
        end
        if (push && !drain) nxt.cnt = cur.cnt + 1'b1;
        else if (!push && drain) nxt.cnt = cur.cnt - 1'b1;
        return nxt;
    endfunction

    // Hand one byte to the C side; a refusal ends the run.
    function automatic void tx_put(input logic [7:0] dat);
        int rc;
        rc = rlink_cext_putbyte_dpi({24'h0, dat});
`ifdef RLINK_CEXT_BUFIO_TRACE_EN
        $display("%0d putbyte %02x", clk_cycle, dat);
`endif
        if (rc != 0) begin
            $display("rlink_cext_bufio: error: putbyte rc=%0d", rc);
            $finish;
        end
    endfunction

    // Per-edge qualifiers from the pre-edge state
    always_comb begin
        rx_poll  = (rx_q.cnt != RX_FULL)
                && (rx_q.bo == '0) && !rx_q.fin;
        rx_pop   = (rx_q.cnt != '0) && !rx_hold;
        tx_push  = tx_ena && !tx_busy;
        tx_drain = (tx_q.cnt != '0) && (tx_q.pace == '0);
    end

    // RX FIFO, poll back-off and end-of-stream flag
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_q <= '0;
        end else if (rx_poll) begin
            rx_q <= rx_next(rx_q, 1'b1,
                rlink_cext_getbyte_dpi(int'(clk_cycle)),
                rx_pop);
        end else begin
            rx_q <= rx_next(rx_q, 1'b0, 0, rx_pop);
        end
    end

    // TX FIFO with paced drain into the C side
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_q <= '0;
        end else begin
            tx_q <= tx_next(tx_q, tx_push, tx_data, tx_drain);
            if (tx_drain) tx_put(tx_q.mem[tx_q.rd]);
        end
    end

    // Sticky overflow when a byte arrives at a full TX FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            ovfl_q <= 1'b0;
        end else if (tx_ena && tx_busy) begin
            ovfl_q <= 1'b1;
            $display("rlink_cext_bufio: error: tx overflow, byte %02x dropped",
                     tx_data);
        end
    end

    assign rx_data = rx_q.mem[rx_q.rd];
    assign rx_val  = (rx_q.cnt != '0);
    assign rx_fill = rx_q.cnt;
    assign tx_fill = tx_q.cnt;
    assign tx_busy = (tx_q.cnt == TX_FULL);
    assign sim_end = rx_q.fin;
    assign tx_ovfl = ovfl_q;

endmodule

// File: tb/tb_rlink_cext_bufio.sv
// tb_rlink_cext_bufio: directed bench for rlink_cext_bufio.
// u_a uses default parameters, u_b a slow-paced small TX FIFO.
module tb_rlink_cext_bufio;

    import rlink_cext_pkg::*;

    typedef struct {
        logic       ena;
        logic [7:0] dat;
        int         fill;
        int         busy;
        int         ovfl;
        int         puts;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_a;
    logic        rst_b;
    logic [31:0] clk_cycle;

    logic [7:0]  a_rx_data, b_rx_data;
    logic        a_rx_val, b_rx_val;
    logic        a_rx_hold, b_rx_hold;
    logic [7:0]  a_tx_data, b_tx_data;
    logic        a_tx_ena, b_tx_ena;
    logic        a_tx_busy, b_tx_busy;
    logic [4:0]  a_rx_fill, b_rx_fill;
    logic [4:0]  a_tx_fill;
    logic [2:0]  b_tx_fill;
    logic        a_sim_end, b_sim_end;
    logic        a_tx_ovfl, b_tx_ovfl;

    int total;
    int bad;
    int cyc;

    always #5 clk = ~clk;

    rlink_cext_bufio #(
        .RXDEPTH(16), .TXDEPTH(16), .POLLWAIT(0), .TXPACE(1)
    ) u_a (
        .clk(clk), .reset(rst_a), .clk_cycle(clk_cycle),
        .rx_data(a_rx_data), .rx_val(a_rx_val), .rx_hold(a_rx_hold),
        .tx_data(a_tx_data), .tx_ena(a_tx_ena), .tx_busy(a_tx_busy),
        .rx_fill(a_rx_fill), .tx_fill(a_tx_fill),
        .sim_end(a_sim_end), .tx_ovfl(a_tx_ovfl)
    );

    rlink_cext_bufio #(
        .RXDEPTH(16), .TXDEPTH(4), .POLLWAIT(5), .TXPACE(4)
    ) u_b (
        .clk(clk), .reset(rst_b), .clk_cycle(clk_cycle),
        .rx_data(b_rx_data), .rx_val(b_rx_val), .rx_hold(b_rx_hold),
        .tx_data(b_tx_data), .tx_ena(b_tx_ena), .tx_busy(b_tx_busy),
        .rx_fill(b_rx_fill), .tx_fill(b_tx_fill),
        .sim_end(b_sim_end), .tx_ovfl(b_tx_ovfl)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        clk_cycle = 32'(cyc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[18];
        int   n0, n1, got, seen;

        vt[0]  = '{1'b1, 8'hA0, 1, 0, 0, 0};
        vt[1]  = '{1'b1, 8'hA1, 1, 0, 0, 1};
        vt[2]  = '{1'b1, 8'hA2, 2, 0, 0, 1};
        vt[3]  = '{1'b1, 8'hA3, 3, 0, 0, 1};
        vt[4]  = '{1'b1, 8'hA4, 4, 1, 0, 1};
        vt[5]  = '{1'b1, 8'hA5, 3, 0, 1, 2};
        vt[6]  = '{1'b0, 8'h00, 3, 0, 1, 2};
        vt[7]  = '{1'b0, 8'h00, 3, 0, 1, 2};
        vt[8]  = '{1'b0, 8'h00, 3, 0, 1, 2};
        vt[9]  = '{1'b0, 8'h00, 2, 0, 1, 3};
        vt[10] = '{1'b0, 8'h00, 2, 0, 1, 3};
        vt[11] = '{1'b0, 8'h00, 2, 0, 1, 3};
        vt[12] = '{1'b0, 8'h00, 2, 0, 1, 3};
        vt[13] = '{1'b0, 8'h00, 1, 0, 1, 4};
        vt[14] = '{1'b0, 8'h00, 1, 0, 1, 4};
        vt[15] = '{1'b0, 8'h00, 1, 0, 1, 4};
        vt[16] = '{1'b0, 8'h00, 1, 0, 1, 4};
        vt[17] = '{1'b0, 8'h00, 0, 0, 1, 5};

        total = 0; bad = 0; cyc = 0;
        clk_cycle = 32'd0;
        rst_a = 1'b1; rst_b = 1'b1;
        a_rx_hold = 1'b0; b_rx_hold = 1'b0;
        a_tx_ena = 1'b0; b_tx_ena = 1'b0;
        a_tx_data = 8'h00; b_tx_data = 8'h00;
        tick(); tick();

        chk("rst_rx_data", int'(a_rx_data), 0);
        chk("rst_rx_val", int'(a_rx_val), 0);
        chk("rst_rx_fill", int'(a_rx_fill), 0);
        chk("rst_tx_fill", int'(a_tx_fill), 0);
        chk("rst_tx_busy", int'(a_tx_busy), 0);
        chk("rst_sim_end", int'(a_sim_end), 0);
        chk("rst_tx_ovfl", int'(a_tx_ovfl), 0);
        chk("rst_no_poll", get_log.size(), 0);

        // streaming, no hold
        for (int i = 0; i < 16; i++) rx_src.push_back(16 + i);
        rst_a = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk($sformatf("stream_val[%0d]", i), int'(a_rx_val), 1);
            chk($sformatf("stream_data[%0d]", i), int'(a_rx_data), 16 + i);
            chk($sformatf("stream_fill[%0d]", i), int'(a_rx_fill <= 5'd1), 1);
        end
        tick();
        chk("stream_drained", int'(a_rx_val), 0);

        // fill to saturation under hold
        a_rx_hold = 1'b1;
        for (int i = 0; i < 20; i++) rx_src.push_back(i);
        repeat (16) tick();
        chk("hold_fill16", int'(a_rx_fill), 16);
        n0 = get_log.size();
        repeat (4) tick();
        chk("hold_fill_stays", int'(a_rx_fill), 16);
        chk("hold_no_poll", get_log.size(), n0);
        chk("hold_src_left", rx_src.size(), 4);
        chk("hold_head", int'(a_rx_data), 0);
        a_rx_hold = 1'b0;
        got = 0;
        for (int k = 0; k < 60 && got < 20; k++) begin
            if (a_rx_val) begin
                chk($sformatf("hold_order[%0d]", got), int'(a_rx_data), got);
                got++;
            end
            tick();
        end
        chk("hold_count", got, 20);
        chk("hold_src_empty", rx_src.size(), 0);

        // end of stream
        a_rx_hold = 1'b1;
        rx_src.push_back(8'h55);
        rx_src.push_back(8'h66);
        rx_src.push_back(-2);
        rx_src.push_back(8'h77);
        tick(); tick();
        n0 = cyc;
        tick();
        chk("end_sim_end", int'(a_sim_end), 1);
        chk("end_cyc_arg", get_log[get_log.size()-1], n0);
        n1 = get_log.size();
        repeat (5) tick();
        chk("end_no_poll", get_log.size(), n1);
        chk("end_src_left", rx_src.size(), 1);
        chk("end_fill", int'(a_rx_fill), 2);
        a_rx_hold = 1'b0;
        tick();
        chk("end_drain_data", int'(a_rx_data), 8'h66);
        chk("end_drain_val", int'(a_rx_val), 1);
        tick();
        chk("end_drained", int'(a_rx_val), 0);
        chk("end_sticky", int'(a_sim_end), 1);
        rst_a = 1'b1;
        tick();
        chk("end_rst_clear", int'(a_sim_end), 0);
        rx_src.delete();
        rx_src.push_back(8'h99);
        rst_a = 1'b0;
        tick();
        chk("end_resume", int'(a_rx_data), 8'h99);
        chk("end_resume_val", int'(a_rx_val), 1);
        rst_a = 1'b1;
        tick();

        // poll back-off on u_b
        get_log.delete();
        rx_src.delete();
        b_rx_hold = 1'b1;
        rst_b = 1'b0;
        repeat (13) tick();
        chk("bo_polls", get_log.size(), 3);
        if (get_log.size() >= 3) begin
            chk("bo_gap0", get_log[1] - get_log[0], 6);
            chk("bo_gap1", get_log[2] - get_log[1], 6);
        end
        rx_src.push_back(8'hC3);
        seen = 0;
        for (int k = 0; k < 10 && !b_rx_val; k++) begin
            tick();
            seen++;
        end
        chk("bo_data_lat", seen, 6);
        chk("bo_data", int'(b_rx_data), 8'hC3);

        // paced TX with overflow
        rst_b = 1'b1;
        tick();
        rx_src.delete();
        put_log.delete();
        b_rx_hold = 1'b0;
        rst_b = 1'b0;
        for (int i = 0; i < 18; i++) begin
            b_tx_ena = vt[i].ena;
            b_tx_data = vt[i].dat;
            tick();
            chk($sformatf("tx_fill[%0d]", i), int'(b_tx_fill), vt[i].fill);
            chk($sformatf("tx_busy[%0d]", i), int'(b_tx_busy), vt[i].busy);
            chk($sformatf("tx_ovfl[%0d]", i), int'(b_tx_ovfl), vt[i].ovfl);
            chk($sformatf("tx_puts[%0d]", i), put_log.size(), vt[i].puts);
        end
        b_tx_ena = 1'b0;
        if (put_log.size() == 5) begin
            for (int i = 0; i < 5; i++)
                chk($sformatf("tx_byte[%0d]", i), put_log[i], 8'hA0 + i);
        end

        // reset mid-stream
        rst_b = 1'b1;
        tick();
        put_log.delete();
        get_log.delete();
        rx_src.delete();
        for (int i = 1; i <= 3; i++) rx_src.push_back(i);
        b_rx_hold = 1'b1;
        rst_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b_tx_ena = 1'b1;
            b_tx_data = 8'(8'h31 + i);
            tick();
        end
        b_tx_ena = 1'b0;
        chk("mid_rx_fill", int'(b_rx_fill), 3);
        chk("mid_tx_fill", int'(b_tx_fill), 2);
        chk("mid_puts", put_log.size(), 1);
        rst_b = 1'b1;
        tick();
        chk("mid_rst_rx_data", int'(b_rx_data), 0);
        chk("mid_rst_rx_val", int'(b_rx_val), 0);
        chk("mid_rst_rx_fill", int'(b_rx_fill), 0);
        chk("mid_rst_tx_fill", int'(b_tx_fill), 0);
        chk("mid_rst_tx_busy", int'(b_tx_busy), 0);
        chk("mid_rst_sim_end", int'(b_sim_end), 0);
        chk("mid_rst_tx_ovfl", int'(b_tx_ovfl), 0);
        tick();
        chk("mid_no_put", put_log.size(), 1);
        chk("mid_no_get", get_log.size(), 3);
        rst_b = 1'b0;
        b_rx_hold = 1'b0;
        rx_src.push_back(8'h42);
        b_tx_ena = 1'b1;
        b_tx_data = 8'h5A;
        tick();
        b_tx_ena = 1'b0;
        chk("post_rx_data", int'(b_rx_data), 8'h42);
        chk("post_rx_val", int'(b_rx_val), 1);
        chk("post_tx_fill", int'(b_tx_fill), 1);
        tick();
        chk("post_puts", put_log.size(), 2);
        if (put_log.size() == 2) chk("post_put_byte", put_log[1], 8'h5A);
        chk("post_rx_fill", int'(b_rx_fill), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
